// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - frame-buffer constants, HDMI timing and arbiter state type
package fb_pkg;

  localparam int FB_BYTES = 256;

  // 1280x720p60 timing
  localparam int H_ACTIVE = 1280;
  localparam int H_TOTAL  = 1650;
  localparam int V_ACTIVE = 720;
  localparam int V_TOTAL  = 750;

  localparam int ACTIVE_V = V_ACTIVE;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    CLEAR
  } fb_arb_state_t;

endpackage

// File: rtl/fb_clear_engine.sv
// rtl/fb_clear_engine.sv - sweeps FB_BYTES addresses after a one-cycle start strobe
module fb_clear_engine #(
  parameter int ADDR_W   = 8,
  parameter int FB_BYTES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              last,
  output logic [ADDR_W-1:0] addr
);

  localparam int CNT_W = ADDR_W + 1;

  // One bit wider than the address so a full 2^ADDR_W sweep ends without wrapping
  logic [CNT_W-1:0] count;

  assign last = busy && (count == CNT_W'(FB_BYTES - 1));
  assign addr = count[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= 1'b0;
      done  <= 1'b0;
      count <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy  <= 1'b1;
        count <= '0;
      end else if (busy) begin
        if (last) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fb_port_arbiter.sv
// rtl/fb_port_arbiter.sv - shares frame-buffer BRAM port A between the CPU and the clear engine
module fb_port_arbiter #(
  parameter int ADDR_W       = 8,
  parameter int FB_BYTES     = fb_pkg::FB_BYTES,
  parameter int READ_LATENCY = 2,
  parameter int ACTIVE_V     = fb_pkg::ACTIVE_V
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [9:0]        vcount_in,
  input  logic              tear_free_in,
  input  logic              cpu_req_in,
  input  logic              cpu_we_in,
  input  logic [ADDR_W-1:0] cpu_addr_in,
  input  logic [7:0]        cpu_data_in,
  output logic              cpu_ack_out,
  output logic [7:0]        cpu_data_out,
  input  logic              clr_req_in,
  output logic              clr_busy_out,
  output logic              clr_done_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic              mem_we_out,
  output logic [7:0]        mem_data_out,
  input  logic [7:0]        mem_data_in
);

  import fb_pkg::*;

  localparam int LAT_W = $clog2(READ_LATENCY + 2);

  fb_arb_state_t state, state_next;

  logic              vblank;
  logic              gate_open;
  logic              clr_pending;
  logic [LAT_W-1:0]  lat_count;
  logic              clr_start;
  logic              do_write;
  logic              do_read;
  logic              rd_done;
  logic              set_pending;
  logic              clr_busy;
  logic              clr_done;
  logic              clr_last;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        data_q;
  logic              we_q;

  assign vblank    = (vcount_in >= 10'(ACTIVE_V));
  assign gate_open = !tear_free_in || vblank;

  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    clr_start   = 1'b0;
    do_write    = 1'b0;
    do_read     = 1'b0;
    rd_done     = 1'b0;
    set_pending = 1'b0;
    case (state)
      IDLE: begin
        if ((clr_pending || clr_req_in) && gate_open) begin
          clr_start  = 1'b1;
          state_next = CLEAR;
        end else begin
          set_pending = clr_req_in;
          if (cpu_req_in && cpu_we_in && gate_open) begin
            do_write = 1'b1;
          end else if (cpu_req_in && !cpu_we_in) begin
            do_read    = 1'b1;
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        set_pending = clr_req_in;
        if (lat_count == LAT_W'(READ_LATENCY)) begin
          rd_done    = 1'b1;
          state_next = IDLE;
        end
      end
      CLEAR: begin
        // Requests arriving mid-clear are dropped; the sweep already covers them
        if (clr_last) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      clr_pending  <= 1'b0;
      lat_count    <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      cpu_ack_out  <= 1'b0;
      cpu_data_out <= '0;
    end else begin
      we_q        <= do_write;
      cpu_ack_out <= do_write || rd_done;
      if (clr_start)        clr_pending <= 1'b0;
      else if (set_pending) clr_pending <= 1'b1;
      if (do_write || do_read) addr_q <= cpu_addr_in;
      if (do_write)            data_q <= cpu_data_in;
      lat_count <= (state == RD_WAIT) ? lat_count + 1'b1 : '0;
      if (rd_done) cpu_data_out <= mem_data_in;
    end
  end

  fb_clear_engine #(
    .ADDR_W   (ADDR_W),
    .FB_BYTES (FB_BYTES)
  ) u_clear (
    .clk   (clk_in),
    .rst   (rst_in),
    .start (clr_start),
    .busy  (clr_busy),
    .done  (clr_done),
    .last  (clr_last),
    .addr  (clr_addr)
  );

  // Both sources are flops; the clear engine owns the port whenever it is busy
  assign mem_addr_out = clr_busy ? clr_addr : addr_q;
  assign mem_we_out   = clr_busy || we_q;
  assign mem_data_out = clr_busy ? 8'h00 : data_q;
  assign clr_busy_out = clr_busy;
  assign clr_done_out = clr_done;

endmodule
